// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter.
// Covers the default widths, the sequencer states and the requester IDs.
package regfile_pkg;

  localparam int DATA_W_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// On a tie, the port that did not win last time is chosen.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_win,
  output logic win_valid,
  output logic win_id
);

  always_comb begin
    win_valid = a_req | b_req;
    win_id    = REQ_A;
    if (a_req && b_req) begin
      win_id = ~last_win;
    end else if (b_req) begin
      win_id = REQ_B;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-master arbiter and sequencer for the 4x4 register file.
// Each transaction gets one ISSUE cycle on the rf buses; reads take an extra WAIT cycle.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_done,
  output logic              b_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rf_write_enable,
  output logic              rf_read_enable,
  output logic [ADDR_W-1:0] rf_write_in_address,
  output logic [ADDR_W-1:0] rf_read_out_address,
  output logic [DATA_W-1:0] rf_write_in_data,
  input  logic [DATA_W-1:0] rf_led
);

  state_e            state_q, state_d;
  logic              last_win_q, last_win_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win_valid;
  logic              win_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .a_req     (a_req),
    .b_req     (b_req),
    .last_win  (last_win_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  assign sel_we    = (win_id == REQ_A) ? a_we    : b_we;
  assign sel_addr  = (win_id == REQ_A) ? a_addr  : b_addr;
  assign sel_wdata = (win_id == REQ_A) ? a_wdata : b_wdata;

  // The rf buses are registers so they keep the last issued address/data between transactions.
  always_comb begin
    state_d         = state_q;
    last_win_d      = last_win_q;
    owner_d         = owner_q;
    we_d            = we_q;
    wr_addr_d       = wr_addr_q;
    rd_addr_d       = rd_addr_q;
    wr_data_d       = wr_data_q;
    rdata_d         = rdata_q;
    a_gnt           = 1'b0;
    b_gnt           = 1'b0;
    a_done          = 1'b0;
    b_done          = 1'b0;
    rf_write_enable = 1'b0;
    rf_read_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d    = ISSUE;
          last_win_d = win_id;
          owner_d    = win_id;
          we_d       = sel_we;
          if (sel_we) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_wdata;
          end else begin
            rd_addr_d = sel_addr;
          end
        end
      end
      ISSUE: begin
        a_gnt           = (owner_q == REQ_A);
        b_gnt           = (owner_q == REQ_B);
        rf_write_enable = we_q;
        rf_read_enable  = ~we_q;
        state_d         = we_q ? DONE : WAIT;
      end
      WAIT: begin
        rdata_d = rf_led;
        state_d = DONE;
      end
      DONE: begin
        a_done  = (owner_q == REQ_A);
        b_done  = (owner_q == REQ_B);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_win_q <= REQ_B;
      owner_q    <= REQ_A;
      we_q       <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_data_q  <= wr_data_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign rdata               = rdata_q;
  assign rf_write_in_address = wr_addr_q;
  assign rf_read_out_address = rd_addr_q;
  assign rf_write_in_data    = wr_data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file beside it.
// Completions are checked against a scoreboard queue filled as requests are driven.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_done, b_done, busy;
  logic [DW-1:0] rdata;
  logic          rf_write_enable, rf_read_enable;
  logic [AW-1:0] rf_write_in_address, rf_read_out_address;
  logic [DW-1:0] rf_write_in_data, rf_led;

  int testCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic          id;
    logic          isRead;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expQ[$];
  exp_t          monE;
  logic [DW-1:0] rfMem[4];

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .a_req               (a_req),
    .a_we                (a_we),
    .a_addr              (a_addr),
    .a_wdata             (a_wdata),
    .b_req               (b_req),
    .b_we                (b_we),
    .b_addr              (b_addr),
    .b_wdata             (b_wdata),
    .a_gnt               (a_gnt),
    .b_gnt               (b_gnt),
    .a_done              (a_done),
    .b_done              (b_done),
    .rdata               (rdata),
    .busy                (busy),
    .rf_write_enable     (rf_write_enable),
    .rf_read_enable      (rf_read_enable),
    .rf_write_in_address (rf_write_in_address),
    .rf_read_out_address (rf_read_out_address),
    .rf_write_in_data    (rf_write_in_data),
    .rf_led              (rf_led)
  );

  // Register file: one-hot reset contents, registered read port.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rfMem[i] <= DW'(1 << i);
      rf_led <= '0;
    end else begin
      if (rf_write_enable) rfMem[rf_write_in_address] <= rf_write_in_data;
      if (rf_read_enable) rf_led <= rfMem[rf_read_out_address];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && (a_done || b_done)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", {30'd0, a_done, b_done}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("sb_done_port", {30'd0, a_done, b_done}, (monE.id == REQ_A) ? 32'd2 : 32'd1);
        if (monE.isRead) checkOutput("sb_rdata", 32'(rdata), 32'(monE.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (port == REQ_A) begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = data;
    end else begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = data;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pushExp(input logic port, input logic isRead, input logic [DW-1:0] data);
    exp_t e;
    e.id = port; e.isRead = isRead; e.data = data;
    expQ.push_back(e);
  endtask

  // One complete transaction from an idle arbiter, checked cycle by cycle.
  task automatic doXact(input string tag, input logic port, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW-1:0] rdExp);
    pushExp(port, !we, rdExp);
    applyStimulus(port, 1'b1, we, addr, data);
    tick();
    checkOutput({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, (port == REQ_A) ? 32'd2 : 32'd1);
    checkOutput({tag, "_en"}, {30'd0, rf_write_enable, rf_read_enable}, we ? 32'd2 : 32'd1);
    if (we) begin
      checkOutput({tag, "_waddr"}, 32'(rf_write_in_address), 32'(addr));
      checkOutput({tag, "_wdata"}, 32'(rf_write_in_data), 32'(data));
    end else begin
      checkOutput({tag, "_raddr"}, 32'(rf_read_out_address), 32'(addr));
    end
    applyStimulus(port, 1'b0, we, addr, data);
    tick();
    checkOutput({tag, "_post_issue"}, {28'd0, a_gnt, b_gnt, rf_write_enable, rf_read_enable}, 32'd0);
    if (!we) begin
      checkOutput({tag, "_wait_nodone"}, {29'd0, a_done, b_done, busy}, 32'd1);
      tick();
    end
    checkOutput({tag, "_done"}, {30'd0, a_done, b_done}, (port == REQ_A) ? 32'd2 : 32'd1);
    tick();
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(REQ_A, 1'b0, 1'b0, '0, '0);
    applyStimulus(REQ_B, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_buses", {22'd0, rf_write_in_address, rf_read_out_address, rf_write_in_data, busy, rf_write_enable}, 32'd0);
    rst = 1'b0;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_outputs", {25'd0, busy, rf_write_enable, rf_read_enable, a_gnt, b_gnt, a_done, b_done}, 32'd0);
    end

    $display("[TB] single write then read on A");
    doXact("a_wr2", REQ_A, 1'b1, 2'd2, 4'hA, 4'h0);
    checkOutput("wr_hold_addr", 32'(rf_write_in_address), 32'd2);
    doXact("a_rd2", REQ_A, 1'b0, 2'd2, 4'h0, 4'hA);
    checkOutput("rd_rdata_hold", 32'(rdata), 32'hA);

    $display("[TB] tie and alternation");
    pulseReset();
    applyStimulus(REQ_A, 1'b1, 1'b1, 2'd0, 4'h5);
    applyStimulus(REQ_B, 1'b1, 1'b1, 2'd1, 4'h6);
    pushExp(REQ_A, 1'b0, 4'h0);
    pushExp(REQ_B, 1'b0, 4'h0);
    pushExp(REQ_A, 1'b0, 4'h0);
    pushExp(REQ_B, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      logic who;
      who = (k % 2 == 0) ? REQ_A : REQ_B;
      tick();
      checkOutput("alt_gnt", {30'd0, a_gnt, b_gnt}, (who == REQ_A) ? 32'd2 : 32'd1);
      if (who == REQ_A) a_req = 1'b0; else b_req = 1'b0;
      tick();
      checkOutput("alt_done", {30'd0, a_done, b_done}, (who == REQ_A) ? 32'd2 : 32'd1);
      if (k < 2) begin
        if (who == REQ_A) a_req = 1'b1; else b_req = 1'b1;
      end
      tick();
      checkOutput("alt_idle", {31'd0, busy}, 32'd0);
    end
    tick();
    checkOutput("alt_quiet", {31'd0, busy}, 32'd0);

    $display("[TB] reads of reset contents by B");
    pulseReset();
    doXact("b_rd0", REQ_B, 1'b0, 2'd0, 4'h0, 4'h1);
    doXact("b_rd1", REQ_B, 1'b0, 2'd1, 4'h0, 4'h2);
    doXact("a_wr0", REQ_A, 1'b1, 2'd0, 4'hF, 4'h0);
    checkOutput("rdata_after_write", 32'(rdata), 32'h2);
    doXact("b_rd2", REQ_B, 1'b0, 2'd2, 4'h0, 4'h4);
    doXact("b_rd3", REQ_B, 1'b0, 2'd3, 4'h0, 4'h8);

    $display("[TB] reset during WAIT");
    applyStimulus(REQ_A, 1'b1, 1'b0, 2'd1, 4'h0);
    tick();
    checkOutput("abort_gnt", {30'd0, a_gnt, rf_read_enable}, 32'd3);
    a_req = 1'b0;
    tick();
    checkOutput("abort_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_rdata", 32'(rdata), 32'd0);
    checkOutput("abort_outputs", {25'd0, busy, rf_write_enable, rf_read_enable, a_gnt, b_gnt, a_done, b_done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_no_done", {29'd0, a_done, b_done, busy}, 32'd0);
    tick();
    checkOutput("abort_no_done2", {29'd0, a_done, b_done, busy}, 32'd0);
    doXact("a_rd3", REQ_A, 1'b0, 2'd3, 4'h0, 4'h8);

    $display("[TB] request ignored while busy");
    pushExp(REQ_A, 1'b0, 4'h0);
    pushExp(REQ_B, 1'b1, 4'h7);
    applyStimulus(REQ_A, 1'b1, 1'b1, 2'd1, 4'h7);
    tick();
    checkOutput("busy_a_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    a_req = 1'b0;
    applyStimulus(REQ_B, 1'b1, 1'b0, 2'd1, 4'h0);
    tick();
    checkOutput("busy_a_done", {29'd0, a_done, b_done, b_gnt}, 32'd4);
    tick();
    checkOutput("busy_idle_no_gnt", {30'd0, b_gnt, busy}, 32'd0);
    tick();
    checkOutput("busy_b_gnt", {29'd0, a_gnt, b_gnt, rf_read_enable}, 32'd3);
    checkOutput("busy_b_raddr", 32'(rf_read_out_address), 32'd1);
    b_req = 1'b0;
    tick();
    checkOutput("busy_b_wait", {30'd0, b_done, busy}, 32'd1);
    tick();
    checkOutput("busy_b_done", {30'd0, a_done, b_done}, 32'd1);
    tick();
    checkOutput("busy_final_idle", {31'd0, busy}, 32'd0);

    tick();
    checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
